mul_issue_scheduler: RTL

- Shares one pipelined 32x32 integer multiplier between two multiply issue queues (requesters 0 and 1).
- Each cycle, at most one op is popped from a queue, chosen round-robin. It is pushed into a LATENCY-stage multiplier pipeline, and results are delivered to the writeback port with ready/valid backpressure.
- Commit-driven flush discards all in-flight work.

---
 rtl/mul_issue_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_issue_scheduler.sv
// Round-robin issue of two multiply queues into one LATENCY-stage 32x32 multiplier.
// Optional MUL_SCHED_PERF_EN adds grant and stall counters.
module mul_issue_scheduler #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [3:0]         req_op,
  input  logic [63:0]        req_src1,
  input  logic [63:0]        req_src2,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         req_pop,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_value,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               wb_src,
  input  logic               flush,
  output logic               busy
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_grant0,
  output logic [31:0]        perf_grant1,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd3;

  logic               r_rr;
  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_src;
  logic [TAG_W-1:0]   r_tag  [LATENCY];
  logic [1:0]         r_op   [LATENCY];
  logic [63:0]        r_prod [LATENCY];

  logic               w_advance;
  logic               w_grant_ok;
  logic [1:0]         w_gnt;
  logic               w_any;
  logic               w_sel;
  logic [1:0]         w_op;
  logic [31:0]        w_a_raw;
  logic [31:0]        w_b_raw;
  logic [TAG_W-1:0]   w_tag;
  logic               w_a_signed;
  logic               w_b_signed;
  logic [63:0]        w_a;
  logic [63:0]        w_b;
  logic [63:0]        w_prod;

  // Global stall: nothing moves while the last stage holds an unaccepted result.
  assign w_advance  = !r_valid[LATENCY-1] || wb_ready;
  assign w_grant_ok = rst && w_advance && !flush;

  assign w_gnt[0] = w_grant_ok && req_valid[0] && (!req_valid[1] || !r_rr);
  assign w_gnt[1] = w_grant_ok && req_valid[1] && (!req_valid[0] ||  r_rr);
  assign w_any    = |w_gnt;
  assign w_sel    = w_gnt[1];
  assign req_pop  = w_gnt;

  assign w_op    = w_sel ? req_op[3:2]        : req_op[1:0];
  assign w_a_raw = w_sel ? req_src1[63:32]    : req_src1[31:0];
  assign w_b_raw = w_sel ? req_src2[63:32]    : req_src2[31:0];
  assign w_tag   = w_sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  // mul/mulh: both signed; mulhsu: src1 signed only; mulhu: both unsigned.
  assign w_a_signed = (w_op != OP_MULHU);
  assign w_b_signed = !w_op[1];
  assign w_a = {{32{w_a_signed & w_a_raw[31]}}, w_a_raw};
  assign w_b = {{32{w_b_signed & w_b_raw[31]}}, w_b_raw};
  // Extended operands make the low 64 bits of the product exact for every op.
  assign w_prod = w_a * w_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= 1'b0;
    end else if (w_any) begin
      r_rr <= ~w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_src   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i]  <= '0;
        r_op[i]   <= '0;
        r_prod[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= w_any;
      r_src[0]   <= w_sel;
      r_tag[0]   <= w_tag;
      r_op[0]    <= w_op;
      r_prod[0]  <= w_prod;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_src[i]   <= r_src[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_op[i]    <= r_op[i-1];
        r_prod[i]  <= r_prod[i-1];
      end
    end
  end

  assign wb_valid = r_valid[LATENCY-1] && !flush;
  assign wb_value = (r_op[LATENCY-1] == OP_MUL) ? r_prod[LATENCY-1][31:0]
                                                : r_prod[LATENCY-1][63:32];
  assign wb_tag   = r_tag[LATENCY-1];
  assign wb_src   = r_src[LATENCY-1];
  assign busy     = |r_valid;

`ifdef MUL_SCHED_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_gnt[0]) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (w_gnt[1]) r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (!w_advance && r_valid[LATENCY-1]) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
